// File: rtl/otg_hpi_sequencer.sv
// Command/response sequencer for the CY7C67200 Host Port Interface: turns accepted
// commands into timed HPI register cycles, including two-phase ADDRESS/DATA memory accesses.
module otg_hpi_sequencer #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mem,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_reg,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_dout,
    output logic        hpi_doe,
    input  logic [15:0] hpi_din,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n
);
    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDRESS = 2'd2;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;   // 0: ADDRESS-register phase of a memory access, 1: DATA phase

    logic        mem_q, write_q;
    logic [1:0]  reg_q;
    logic [15:0] addr_q, wdata_q;

    logic        accept;
    logic        mem_n, write_n;
    logic [1:0]  reg_n;
    logic [15:0] addr_n, wdata_n;

    logic        ph_write_q, ph_write_n;
    logic [1:0]  ph_reg_n;
    logic [15:0] ph_data_n;

    logic        cs_n_d, rd_n_d, wr_n_d, doe_d, rsp_valid_d;
    logic [1:0]  hpi_addr_d;
    logic [15:0] hpi_dout_d;

    assign accept    = (state_q == IDLE) && cmd_valid;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    // Command fields as they will be after this edge, so outputs for SETUP can be registered at accept.
    assign mem_n   = accept ? cmd_mem   : mem_q;
    assign write_n = accept ? cmd_write : write_q;
    assign reg_n   = accept ? cmd_reg   : reg_q;
    assign addr_n  = accept ? cmd_addr  : addr_q;
    assign wdata_n = accept ? cmd_wdata : wdata_q;

    assign ph_write_q = phase_q ? write_q : 1'b1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    phase_d = ~cmd_mem;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!phase_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    phase_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pin values for the cycle after this edge, decoded from the next state and phase.
    always_comb begin
        ph_write_n = phase_d ? write_n : 1'b1;
        ph_reg_n   = !phase_d ? REG_ADDRESS : (mem_n ? REG_DATA : reg_n);
        ph_data_n  = phase_d ? wdata_n : addr_n;

        cs_n_d     = !(state_d inside {SETUP, STROBE, HOLD});
        rd_n_d     = !((state_d == STROBE) && !ph_write_n);
        wr_n_d     = !((state_d == STROBE) && ph_write_n);
        doe_d      = !cs_n_d && ph_write_n;
        hpi_addr_d = cs_n_d ? hpi_addr : ph_reg_n;
        hpi_dout_d = doe_d ? ph_data_n : hpi_dout;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            phase_q   <= 1'b0;
            mem_q     <= 1'b0;
            write_q   <= 1'b0;
            reg_q     <= 2'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            hpi_cs_n  <= 1'b1;
            hpi_rd_n  <= 1'b1;
            hpi_wr_n  <= 1'b1;
            hpi_doe   <= 1'b0;
            hpi_addr  <= 2'd0;
            hpi_dout  <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            if (accept) begin
                mem_q   <= cmd_mem;
                write_q <= cmd_write;
                reg_q   <= cmd_reg;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            hpi_cs_n  <= cs_n_d;
            hpi_rd_n  <= rd_n_d;
            hpi_wr_n  <= wr_n_d;
            hpi_doe   <= doe_d;
            hpi_addr  <= hpi_addr_d;
            hpi_dout  <= hpi_dout_d;
            rsp_valid <= rsp_valid_d;
            // Read data is captured at the edge that ends the last strobe-low cycle.
            if ((state_q == STROBE) && (cnt_q == 4'd0) && !ph_write_q) begin
                rsp_rdata <= hpi_din;
            end
        end
    end
endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Bench for otg_hpi_sequencer: two instances (default and alternate timing) checked every
// cycle against a cycle-offset model of the HPI access timing, plus literal spot checks.
`timescale 1ns/1ps
module tb_otg_hpi_sequencer;
    localparam int NI = 2;
    localparam int S_C [NI] = '{1, 2};
    localparam int T_C [NI] = '{4, 1};
    localparam int H_C [NI] = '{1, 3};
    localparam int R_C [NI] = '{2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_mem, cmd_write;
    logic [1:0]  cmd_reg;
    logic [15:0] cmd_addr, cmd_wdata;

    logic        cmd_ready [NI];
    logic        rsp_valid [NI];
    logic [15:0] rsp_rdata [NI];
    logic        busy      [NI];
    logic [1:0]  hpi_addr  [NI];
    logic [15:0] hpi_dout  [NI];
    logic        hpi_doe   [NI];
    logic [15:0] hpi_din   [NI];
    logic        hpi_cs_n  [NI];
    logic        hpi_rd_n  [NI];
    logic        hpi_wr_n  [NI];

    otg_hpi_sequencer #(.SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_mem(cmd_mem), .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .hpi_addr(hpi_addr[0]), .hpi_dout(hpi_dout[0]), .hpi_doe(hpi_doe[0]), .hpi_din(hpi_din[0]),
        .hpi_cs_n(hpi_cs_n[0]), .hpi_rd_n(hpi_rd_n[0]), .hpi_wr_n(hpi_wr_n[0])
    );

    otg_hpi_sequencer #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVER_CYC(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_mem(cmd_mem), .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .hpi_addr(hpi_addr[1]), .hpi_dout(hpi_dout[1]), .hpi_doe(hpi_doe[1]), .hpi_din(hpi_din[1]),
        .hpi_cs_n(hpi_cs_n[1]), .hpi_rd_n(hpi_rd_n[1]), .hpi_wr_n(hpi_wr_n[1])
    );

    always #5 clk = ~clk;

    // Model state: k = cycles since accept (0 when idle).
    int          k         [NI];
    bit          m_mem     [NI];
    bit          m_wr      [NI];
    logic [1:0]  m_reg     [NI];
    logic [15:0] m_addr    [NI];
    logic [15:0] m_wdata   [NI];
    logic [15:0] exp_rdata [NI];
    logic [15:0] chip_val  [NI];
    logic [15:0] din_drv   [NI];
    int          acc_cycle [NI];
    int          dut_lat   [NI];
    int          cs_run    [NI];
    int          cs_gap    [NI];
    int          cyc;
    bit          din_steady;
    int          vectors;
    int          miscompares;

    function automatic int plen(int i);
        return S_C[i] + T_C[i] + H_C[i] + R_C[i];
    endfunction

    function automatic int tlen(int i);
        return m_mem[i] ? 2 * plen(i) : plen(i);
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    // What the pins must look like kk cycles after accept.
    task automatic decode(input int i, input int kk, output bit act, output bit strb, output bit wr,
                          output logic [1:0] a, output logic [15:0] d, output bit last_rd);
        int  p;
        int  j;
        bit  data_ph;
        p       = plen(i);
        data_ph = !(m_mem[i] && kk <= p);
        j       = (m_mem[i] && data_ph) ? kk - p : kk;
        wr      = data_ph ? m_wr[i] : 1'b1;
        a       = !data_ph ? 2'd2 : (m_mem[i] ? 2'd0 : m_reg[i]);
        d       = data_ph ? m_wdata[i] : m_addr[i];
        act     = (j <= S_C[i] + T_C[i] + H_C[i]);
        strb    = (j > S_C[i]) && (j <= S_C[i] + T_C[i]);
        last_rd = strb && !wr && (j == S_C[i] + T_C[i]);
    endtask

    task automatic compare(input int i, input bit rsp_e);
        bit          a_, s_, w_, l_;
        logic [1:0]  ad;
        logic [15:0] dd;
        check("rsp_rdata", i, rsp_rdata[i], exp_rdata[i]);
        check("rsp_valid", i, rsp_valid[i], rsp_e);
        if (k[i] == 0) begin
            check("cs_n", i, hpi_cs_n[i], 1);
            check("rd_n", i, hpi_rd_n[i], 1);
            check("wr_n", i, hpi_wr_n[i], 1);
            check("doe", i, hpi_doe[i], 0);
            check("busy", i, busy[i], 0);
            check("cmd_ready", i, cmd_ready[i], 1);
        end else begin
            decode(i, k[i], a_, s_, w_, ad, dd, l_);
            check("cs_n", i, hpi_cs_n[i], !a_);
            check("rd_n", i, hpi_rd_n[i], !(s_ && !w_));
            check("wr_n", i, hpi_wr_n[i], !(s_ && w_));
            check("doe", i, hpi_doe[i], a_ && w_);
            check("busy", i, busy[i], 1);
            check("cmd_ready", i, cmd_ready[i], 0);
            if (a_) check("hpi_addr", i, hpi_addr[i], ad);
            if (a_ && w_) check("hpi_dout", i, hpi_dout[i], dd);
        end
        if (rsp_valid[i] === 1'b1) dut_lat[i] = cyc - acc_cycle[i];
        if (hpi_cs_n[i] === 1'b1) begin
            cs_run[i]++;
        end else begin
            if (cs_run[i] > 0) cs_gap[i] = cs_run[i];
            cs_run[i] = 0;
        end
    endtask

    task automatic step();
        bit          acc [NI];
        bit          lr  [NI];
        bit          rsp_e;
        bit          a_, s_, w_, l_;
        logic [1:0]  ad;
        logic [15:0] dd;
        for (int i = 0; i < NI; i++) begin
            lr[i] = 1'b0;
            if (k[i] > 0) begin
                decode(i, k[i], a_, s_, w_, ad, dd, l_);
                lr[i] = l_;
            end
            acc[i] = cmd_valid && (k[i] == 0);
            if (acc[i]) begin
                m_mem[i]     = cmd_mem;
                m_wr[i]      = cmd_write;
                m_reg[i]     = cmd_reg;
                m_addr[i]    = cmd_addr;
                m_wdata[i]   = cmd_wdata;
                acc_cycle[i] = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            rsp_e = 1'b0;
            if (lr[i]) exp_rdata[i] = din_drv[i];
            if (k[i] > 0) begin
                k[i]++;
                if (k[i] == tlen(i) + 1) begin
                    k[i]  = 0;
                    rsp_e = 1'b1;
                end
            end else if (acc[i]) begin
                k[i] = 1;
            end
            compare(i, rsp_e);
            din_drv[i] = 16'($urandom);
            if (din_steady && k[i] > 0) begin
                decode(i, k[i], a_, s_, w_, ad, dd, l_);
                if (s_ && !w_) din_drv[i] = chip_val[i];
            end
            hpi_din[i] = din_drv[i];
        end
    endtask

    task automatic scramble();
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
        {cmd_mem, cmd_write, cmd_reg} = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((k[0] != 0 || k[1] != 0) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout t=%0t waited %0d cycles, required fewer than 100", $time, n);
        end
    endtask

    task automatic run_cmd(input bit mem, input bit wr, input logic [1:0] rg,
                           input logic [15:0] ad, input logic [15:0] wd);
        wait_idle();
        dut_lat[0] = -1;
        dut_lat[1] = -1;
        cmd_valid = 1'b1;
        cmd_mem   = mem;
        cmd_write = wr;
        cmd_reg   = rg;
        cmd_addr  = ad;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        scramble();
        wait_idle();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            k[i]         = 0;
            exp_rdata[i] = 16'd0;
            dut_lat[i]   = -1;
            cs_run[i]    = 0;
            cs_gap[i]    = 0;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog t=%0t simulation did not finish in time", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int n;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        din_steady  = 1'b1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            hpi_din[i]  = 16'd0;
            din_drv[i]  = 16'd0;
            chip_val[i] = 16'd0;
            acc_cycle[i] = 0;
        end
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mem   = 1'b0;
        cmd_write = 1'b0;
        cmd_reg   = 2'd0;
        cmd_addr  = 16'd0;
        cmd_wdata = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_cs_n", i, hpi_cs_n[i], 1);
            check("rst_rd_n", i, hpi_rd_n[i], 1);
            check("rst_wr_n", i, hpi_wr_n[i], 1);
            check("rst_doe", i, hpi_doe[i], 0);
            check("rst_addr", i, hpi_addr[i], 0);
            check("rst_dout", i, hpi_dout[i], 0);
            check("rst_rsp_valid", i, rsp_valid[i], 0);
            check("rst_rdata", i, rsp_rdata[i], 0);
            check("rst_busy", i, busy[i], 0);
            check("rst_ready", i, cmd_ready[i], 1);
        end
        #2 reset_n = 1'b1;
        step();
        step();

        // Single write to MAILBOX.
        run_cmd(1'b0, 1'b1, 2'd1, 16'h0000, 16'hBEEF);
        check("lat_single_wr", 0, dut_lat[0], 9);
        check("lat_single_wr", 1, dut_lat[1], 8);

        // Single read of STATUS; the chip returns 0x1234 while strobed.
        chip_val[0] = 16'h1234;
        chip_val[1] = 16'h1234;
        run_cmd(1'b0, 1'b0, 2'd3, 16'h0000, 16'h0000);
        check("lat_single_rd", 0, dut_lat[0], 9);
        check("lat_single_rd", 1, dut_lat[1], 8);
        check("rdata_single", 0, rsp_rdata[0], 16'h1234);
        check("rdata_single", 1, rsp_rdata[1], 16'h1234);

        // Memory read from 0x1000.
        chip_val[0] = 16'h5A5A;
        chip_val[1] = 16'h5A5A;
        run_cmd(1'b1, 1'b0, 2'd0, 16'h1000, 16'h0000);
        check("lat_mem_rd", 0, dut_lat[0], 17);
        check("lat_mem_rd", 1, dut_lat[1], 15);
        check("rdata_mem", 0, rsp_rdata[0], 16'h5A5A);
        check("rdata_mem", 1, rsp_rdata[1], 16'h5A5A);

        // Memory write leaves the read data untouched.
        run_cmd(1'b1, 1'b1, 2'd0, 16'h2000, 16'hCAFE);
        check("lat_mem_wr", 0, dut_lat[0], 17);
        check("rdata_after_wr", 0, rsp_rdata[0], 16'h5A5A);

        // Back-to-back: cmd_valid held high across the busy period and the completion cycle.
        wait_idle();
        cmd_valid = 1'b1;
        cmd_mem   = 1'b0;
        cmd_write = 1'b1;
        cmd_reg   = 2'd1;
        cmd_wdata = 16'h1111;
        step();
        first_acc = acc_cycle[0];
        n = 0;
        while (acc_cycle[0] == first_acc && n < 50) begin
            step();
            n++;
        end
        cmd_valid = 1'b0;
        check("b2b_accept_cycle", 0, acc_cycle[0] - first_acc, 9);
        wait_idle();
        check("b2b_min_cs_gap", 0, cs_gap[0] >= R_C[0], 1);
        check("b2b_lat", 0, dut_lat[0], 9);

        // Reset pulsed while both instances are in STROBE of a write.
        wait_idle();
        cmd_valid = 1'b1;
        cmd_mem   = 1'b0;
        cmd_write = 1'b1;
        cmd_reg   = 2'd1;
        cmd_wdata = 16'hA5A5;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("pre_rst_wr_n", 0, hpi_wr_n[0], 0);
        check("pre_rst_wr_n", 1, hpi_wr_n[1], 0);
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_rst_cs_n", i, hpi_cs_n[i], 1);
            check("async_rst_wr_n", i, hpi_wr_n[i], 1);
            check("async_rst_rd_n", i, hpi_rd_n[i], 1);
            check("async_rst_doe", i, hpi_doe[i], 0);
        end
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (12) step();
        check("post_rst_ready", 0, cmd_ready[0], 1);
        check("post_rst_ready", 1, cmd_ready[1], 1);

        // Randomized traffic with inputs changing every cycle and noisy read data.
        din_steady = 1'b0;
        repeat (1500) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            scramble();
            step();
        end
        cmd_valid = 1'b0;
        wait_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
